// File: rtl/arf_commit_sequencer_pkg.sv
// Shared constants for the ARF commit sequencer slice: register-file geometry
// and the hard-wired zero register index.
package arf_commit_sequencer_pkg;

  localparam int unsigned ARF_REG_W    = 4;
  localparam int unsigned ARF_DATA_W   = 32;
  localparam int unsigned ARF_ZERO_REG = 0;
  localparam int unsigned ARF_DEPTH    = 4;

endpackage

// File: rtl/arf_fwd_lookup.sv
// Youngest-match search over the commit buffer for one ARF read port.
// Ports:
//   entry_valid/entry_reg/entry_data : buffer contents, indexed by slot
//   head                             : slot of the oldest entry
//   rd_reg, arf_rdata                : reader index and raw ARF data
//   fwd_data_c                       : forwarded data (combinational)
module arf_fwd_lookup
  import arf_commit_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH  = ARF_DEPTH,
  parameter int unsigned REG_W  = ARF_REG_W,
  parameter int unsigned DATA_W = ARF_DATA_W,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             entry_valid,
  input  logic [DEPTH-1:0][REG_W-1:0]  entry_reg,
  input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
  input  logic [PTR_W-1:0]             head,
  input  logic [REG_W-1:0]             rd_reg,
  input  logic [DATA_W-1:0]            arf_rdata,
  output logic [DATA_W-1:0]            fwd_data_c
);

  // Walk from oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    fwd_data_c = arf_rdata;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((rd_reg != REG_W'(ARF_ZERO_REG)) && entry_valid[idx] && (entry_reg[idx] == rd_reg)) begin
        fwd_data_c = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/arf_commit_sequencer.sv
// Buffers up to two in-order ROB commits per cycle and drains one per cycle
// into the single ARF write port; forwards pending data to ARF readers.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   c0_*/c1_*                          : commit lanes (lane 0 is older)
//   commit_ready                       : room for two commits this cycle
//   arf_write_enable/reg/data          : ARF write port (head of buffer)
//   rd_reg1/2, arf_rdata1/2            : reader indices and raw ARF data
//   rd_data1/2                         : read data with pending commits forwarded
//   occupancy                          : number of valid buffer entries
module arf_commit_sequencer
  import arf_commit_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH  = ARF_DEPTH,
  parameter int unsigned REG_W  = ARF_REG_W,
  parameter int unsigned DATA_W = ARF_DATA_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_valid,
  input  logic [REG_W-1:0]  c0_reg,
  input  logic [DATA_W-1:0] c0_data,
  input  logic              c1_valid,
  input  logic [REG_W-1:0]  c1_reg,
  input  logic [DATA_W-1:0] c1_data,
  output logic              commit_ready,
  output logic [REG_W-1:0]  arf_write_reg,
  output logic              arf_write_enable,
  output logic [DATA_W-1:0] arf_write_data,
  input  logic [REG_W-1:0]  rd_reg1,
  input  logic [REG_W-1:0]  rd_reg2,
  input  logic [DATA_W-1:0] arf_rdata1,
  input  logic [DATA_W-1:0] arf_rdata2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [OCC_W-1:0]  occupancy
);

  logic [PTR_W-1:0]             head_q;
  logic [PTR_W-1:0]             tail_q;
  logic [OCC_W-1:0]             occ_q;
  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][REG_W-1:0]  reg_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  logic             en0;
  logic             en1;
  logic             deq;
  logic [1:0]       n_enq;
  logic [PTR_W-1:0] slot1;
  logic [OCC_W-1:0] occ_next;

  // Ready is judged from registered occupancy only, so a dual commit always fits.
  assign commit_ready = (occ_q <= OCC_W'(DEPTH - 2));

  // Register-0 writes are architecturally meaningless and are dropped here.
  assign en0   = commit_ready && c0_valid && (c0_reg != REG_W'(ARF_ZERO_REG));
  assign en1   = commit_ready && c1_valid && (c1_reg != REG_W'(ARF_ZERO_REG));
  assign n_enq = {1'b0, en0} + {1'b0, en1};
  assign deq   = (occ_q != '0);

  // Lane 1 lands right after lane 0, or in lane 0's slot if lane 0 was dropped.
  assign slot1    = tail_q + PTR_W'(en0);
  assign occ_next = occ_q + OCC_W'(n_enq) - OCC_W'(deq);

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      valid_q <= '0;
      reg_q   <= '0;
      data_q  <= '0;
    end else begin
      head_q <= head_q + PTR_W'(deq);
      tail_q <= tail_q + PTR_W'(n_enq);
      occ_q  <= occ_next;
      // Enqueue never targets the head slot while it drains: ready implies two free slots.
      if (deq) begin
        valid_q[head_q] <= 1'b0;
      end
      if (en0) begin
        valid_q[tail_q] <= 1'b1;
        reg_q[tail_q]   <= c0_reg;
        data_q[tail_q]  <= c0_data;
      end
      if (en1) begin
        valid_q[slot1] <= 1'b1;
        reg_q[slot1]   <= c1_reg;
        data_q[slot1]  <= c1_data;
      end
    end
  end

  // Head entry drives the write port directly from state.
  assign arf_write_enable = deq;
  assign arf_write_reg    = deq ? reg_q[head_q]  : '0;
  assign arf_write_data   = deq ? data_q[head_q] : '0;
  assign occupancy        = occ_q;

  arf_fwd_lookup #(
    .DEPTH (DEPTH),
    .REG_W (REG_W),
    .DATA_W(DATA_W)
  ) u_fwd1 (
    .entry_valid(valid_q),
    .entry_reg  (reg_q),
    .entry_data (data_q),
    .head       (head_q),
    .rd_reg     (rd_reg1),
    .arf_rdata  (arf_rdata1),
    .fwd_data_c (rd_data1)
  );

  arf_fwd_lookup #(
    .DEPTH (DEPTH),
    .REG_W (REG_W),
    .DATA_W(DATA_W)
  ) u_fwd2 (
    .entry_valid(valid_q),
    .entry_reg  (reg_q),
    .entry_data (data_q),
    .head       (head_q),
    .rd_reg     (rd_reg2),
    .arf_rdata  (arf_rdata2),
    .fwd_data_c (rd_data2)
  );

endmodule

// File: tb/tb_arf_commit_sequencer.sv
// Scoreboard bench: stimulus pushes accepted commits into an expected-write
// queue and a pending-buffer model; a negedge monitor pops on every ARF write.
module tb_arf_commit_sequencer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        c0_valid;
  logic [3:0]  c0_reg;
  logic [31:0] c0_data;
  logic        c1_valid;
  logic [3:0]  c1_reg;
  logic [31:0] c1_data;
  logic        commit_ready;
  logic [3:0]  arf_write_reg;
  logic        arf_write_enable;
  logic [31:0] arf_write_data;
  logic [3:0]  rd_reg1;
  logic [3:0]  rd_reg2;
  logic [31:0] arf_rdata1;
  logic [31:0] arf_rdata2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic [2:0]  occupancy;

  int   n_checks = 0;
  int   n_err    = 0;
  ent_t exp_wr[$];
  ent_t m_buf[$];

  arf_commit_sequencer #(.DEPTH(DEPTH), .REG_W(4), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .c0_valid        (c0_valid),
    .c0_reg          (c0_reg),
    .c0_data         (c0_data),
    .c1_valid        (c1_valid),
    .c1_reg          (c1_reg),
    .c1_data         (c1_data),
    .commit_ready    (commit_ready),
    .arf_write_reg   (arf_write_reg),
    .arf_write_enable(arf_write_enable),
    .arf_write_data  (arf_write_data),
    .rd_reg1         (rd_reg1),
    .rd_reg2         (rd_reg2),
    .arf_rdata1      (arf_rdata1),
    .arf_rdata2      (arf_rdata2),
    .rd_data1        (rd_data1),
    .rd_data2        (rd_data2),
    .occupancy       (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest pending entry for the register wins; r0 never forwards.
  function automatic logic [31:0] fwd(input logic [3:0] q, input logic [31:0] a);
    logic [31:0] r;
    r = a;
    if (q != 4'd0) begin
      foreach (m_buf[i]) if (m_buf[i].r == q) r = m_buf[i].d;
    end
    return r;
  endfunction

  // Monitor: every ARF write must match the oldest outstanding commit.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("occ_vs_scoreboard", 32'(occupancy), 32'(exp_wr.size()));
      if (arf_write_enable) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'(arf_write_enable), 32'd0);
        end else begin
          ent_t e;
          e = exp_wr.pop_front();
          chk("wr_reg", 32'(arf_write_reg), 32'(e.r));
          chk("wr_data", arf_write_data, e.d);
        end
      end else begin
        chk("idle_reg", 32'(arf_write_reg), 32'd0);
        chk("idle_data", arf_write_data, 32'd0);
      end
    end
  end

  // One cycle of stimulus; checks pre-edge state and updates the model for the edge.
  task automatic step(input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                      input logic v1, input logic [3:0] r1, input logic [31:0] d1,
                      input logic [3:0] q1, input logic [31:0] a1,
                      input logic [3:0] q2, input logic [31:0] a2,
                      output logic accepted);
    logic rdy;
    ent_t e;
    @(negedge clk);
    #1;
    c0_valid = v0; c0_reg = r0; c0_data = d0;
    c1_valid = v1; c1_reg = r1; c1_data = d1;
    rd_reg1 = q1; arf_rdata1 = a1;
    rd_reg2 = q2; arf_rdata2 = a2;
    #1;
    rdy = (m_buf.size() <= DEPTH - 2);
    chk("occupancy", 32'(occupancy), 32'(m_buf.size()));
    chk("commit_ready", 32'(commit_ready), 32'(rdy));
    chk("rd_data1", rd_data1, fwd(q1, a1));
    chk("rd_data2", rd_data2, fwd(q2, a2));
    if (m_buf.size() != 0) void'(m_buf.pop_front());
    if (rdy) begin
      if (v0 && r0 != 4'd0) begin e.r = r0; e.d = d0; m_buf.push_back(e); exp_wr.push_back(e); end
      if (v1 && r1 != 4'd0) begin e.r = r1; e.d = d1; m_buf.push_back(e); exp_wr.push_back(e); end
    end
    accepted = rdy;
  endtask

  // Commit step with random readers.
  task automatic cstep(input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [3:0] r1, input logic [31:0] d1,
                       output logic accepted);
    step(v0, r0, d0, v1, r1, d1, 4'($urandom_range(0, 15)), $urandom,
         4'($urandom_range(0, 15)), $urandom, accepted);
  endtask

  initial begin
    logic acc;
    logic pv0, pv1;
    logic [3:0] pr0, pr1;
    logic [31:0] pd0, pd1;

    rst_n = 1'b0;
    c0_valid = 0; c0_reg = 0; c0_data = 0;
    c1_valid = 0; c1_reg = 0; c1_data = 0;
    rd_reg1 = 0; rd_reg2 = 0; arf_rdata1 = 0; arf_rdata2 = 0;
    #1;
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_wen", 32'(arf_write_enable), 32'd0);
    chk("rst_ready", 32'(commit_ready), 32'd1);
    #11 rst_n = 1'b1;

    // Reset mid-drain with three entries queued.
    cstep(1, 4'd1, 32'h0000_0101, 1, 4'd2, 32'h0000_0202, acc);
    cstep(1, 4'd3, 32'h0000_0303, 1, 4'd6, 32'h0000_0606, acc);
    @(negedge clk);
    #1;
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_occupancy", 32'(occupancy), 32'd0);
    chk("midrst_wen", 32'(arf_write_enable), 32'd0);
    chk("midrst_wreg", 32'(arf_write_reg), 32'd0);
    chk("midrst_ready", 32'(commit_ready), 32'd1);
    exp_wr.delete();
    m_buf.delete();
    c0_valid = 0; c1_valid = 0;
    #1 rst_n = 1'b1;

    // Dual commit, drained in order.
    cstep(1, 4'd2, 32'hABCD_EFAB, 1, 4'd4, 32'h1234_5678, acc);
    for (int i = 0; i < 3; i++) cstep(0, 0, 0, 0, 0, 0, acc);

    // Back-to-back dual commits with the ROB holding rejected pairs.
    for (int i = 0; i < 5; i++) begin
      logic [3:0] ra, rb;
      ra = 4'(i * 2 + 1);
      rb = 4'(i * 2 + 2);
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++)
        cstep(1, ra, 32'hA000_0000 + 32'(i), 1, rb, 32'hB000_0000 + 32'(i), acc);
      chk("hold_accepted", 32'(acc), 32'd1);
    end
    for (int i = 0; i < DEPTH + 2; i++) cstep(0, 0, 0, 0, 0, 0, acc);

    // Register 0 dropped, lane 1 still enqueued.
    cstep(1, 4'd0, 32'hFFFF_FFFF, 1, 4'd5, 32'h0000_0055, acc);
    cstep(0, 0, 0, 0, 0, 0, acc);
    cstep(0, 0, 0, 0, 0, 0, acc);

    // Same register twice: youngest value forwarded until drained.
    step(1, 4'd3, 32'h1111_1111, 1, 4'd3, 32'h2222_2222, 4'd3, 0, 4'd3, 32'h5, acc);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 4'd3, 0, 4'd0, 32'h9, acc);

    // Alternating single/dual commits across the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++) begin
        if (i % 2 == 0) cstep(1, 4'(i + 1), 32'hC0 + 32'(i), 0, 0, 0, acc);
        else            cstep(1, 4'(i + 1), 32'hD0 + 32'(i), 1, 4'(15 - i), 32'hE0 + 32'(i), acc);
      end
    end

    // Random traffic; a rejected pair is held until accepted.
    acc = 1'b1;
    pv0 = 0; pv1 = 0; pr0 = 0; pr1 = 0; pd0 = 0; pd1 = 0;
    for (int i = 0; i < 300; i++) begin
      if (acc) begin
        pv0 = ($urandom_range(0, 3) != 0);
        pv1 = ($urandom_range(0, 2) != 0);
        pr0 = 4'($urandom_range(0, 15));
        pr1 = 4'($urandom_range(0, 15));
        pd0 = $urandom;
        pd1 = $urandom;
      end
      // c1 alone also exercises single-entry enqueue on lane 1.
      cstep(pv0, pr0, pd0, pv1, pr1, pd1, acc);
    end

    for (int i = 0; i < DEPTH + 2; i++) cstep(0, 0, 0, 0, 0, 0, acc);
    @(negedge clk);
    #1;
    chk("drained", 32'(exp_wr.size()), 32'd0);
    chk("final_occ", 32'(occupancy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
